// File: rtl/mmu_skew_feeder.sv
// Upstream feeder for the 4x4 systolic MMU: buffers one data tile and one weight
// tile, then streams both as diagonally skewed wavefronts followed by a zero drain.
`timescale 1ns/1ps

module mmu_skew_feeder #(
    parameter int unsigned depth        = 4,
    parameter int unsigned bit_width    = 8,
    parameter int unsigned flush_cycles = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic                         wr_sel,
    input  logic [$clog2(depth)-1:0]     wr_row,
    input  logic [depth*bit_width-1:0]   wr_data,
    input  logic                         start,
    output logic [depth*bit_width-1:0]   data_arr,
    output logic [depth*bit_width-1:0]   wt_arr,
    output logic                         control,
    output logic                         busy,
    output logic                         done
);

    localparam int unsigned ROW_W     = $clog2(depth);
    localparam int unsigned STEP_W    = $clog2(2*depth);
    localparam int unsigned FLUSH_W   = 8;
    localparam int unsigned STEP_LAST = 2*depth - 2;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_FLUSH  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    // Element c of a row sits at index depth-1-c, matching the bus lane order.
    typedef logic [depth-1:0][bit_width-1:0] row_t;

    row_t dbuf_q [depth];
    row_t wbuf_q [depth];

    logic [1:0]         state_q, state_d;
    logic [STEP_W-1:0]  step_q,  step_d;
    logic [FLUSH_W-1:0] flush_q, flush_d;
    row_t               data_q,  data_d;
    row_t               wt_q,    wt_d;
    logic               control_q, control_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;
    logic               wr_go_c;

    // Next-state, tile write enable and registered-output next values.
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        flush_d   = flush_q;
        data_d    = '0;
        wt_d      = '0;
        control_d = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        wr_go_c   = (state_q == S_IDLE) && wr_en && !start;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_STREAM;
                    step_d  = '0;
                end
            end
            S_STREAM: begin
                if (step_q == STEP_W'(STEP_LAST)) begin
                    state_d = S_FLUSH;
                    flush_d = '0;
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
            S_FLUSH: begin
                if (flush_q == FLUSH_W'(flush_cycles - 1)) begin
                    state_d = S_DONE;
                end else begin
                    flush_d = flush_q + FLUSH_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Lane k carries row (step - k) of each tile, so lane k lags lane 0 by k cycles.
        if (state_d == S_STREAM) begin
            for (int k = 0; k < int'(depth); k++) begin
                if ((int'(step_d) >= k) && ((int'(step_d) - k) < int'(depth))) begin
                    data_d[ROW_W'(int'(depth) - 1 - k)] =
                        dbuf_q[ROW_W'(int'(step_d) - k)][ROW_W'(int'(depth) - 1 - k)];
                    wt_d[ROW_W'(int'(depth) - 1 - k)] =
                        wbuf_q[ROW_W'(int'(step_d) - k)][ROW_W'(int'(depth) - 1 - k)];
                end
            end
        end

        control_d = (state_d == S_STREAM) || (state_d == S_FLUSH);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
    end

    // State, counters and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            step_q    <= '0;
            flush_q   <= '0;
            data_q    <= '0;
            wt_q      <= '0;
            control_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            flush_q   <= flush_d;
            data_q    <= data_d;
            wt_q      <= wt_d;
            control_q <= control_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Tile storage; contents persist across runs and clear only on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < int'(depth); r++) begin
                dbuf_q[r] <= '0;
                wbuf_q[r] <= '0;
            end
        end else if (wr_go_c) begin
            if (wr_sel) begin
                wbuf_q[wr_row] <= wr_data;
            end else begin
                dbuf_q[wr_row] <= wr_data;
            end
        end
    end

    assign data_arr = data_q;
    assign wt_arr   = wt_q;
    assign control  = control_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
